// File: rtl/bw_rate_if.sv
// bw_rate_if: valid/ready credit channel from the shaper
// to the TX rate buffer.
interface bw_rate_if #(
  parameter int DW = 17
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/bw_shaper.sv
// bw_shaper: per-stream phase-accumulator rate shaper with
// round-robin credit grant onto the rate buffer channel.
module bw_shaper #(
  parameter int          STR_NUM   = 8,
  parameter int          ACC_W     = 16,
  parameter int          SCAL_W    = 32,
  parameter int          LEN_W     = 14,
  parameter int          PEND_W    = 4,
  parameter logic [11:0] BASE_ADDR = 12'h100,
  localparam int         IDW = (STR_NUM > 1) ?
                               $clog2(STR_NUM) : 1
) (
  input  logic               up_clk,
  input  logic               rst,
  input  logic               up_wr,
  input  logic               up_rd,
  input  logic [31:0]        up_addr,
  input  logic [31:0]        up_data_wr,
  output logic [31:0]        up_data_rd,
  input  logic               tx_test_pulse,
  input  logic               tx_test_level,
  bw_rate_if.master          bw_rate,
  output logic [STR_NUM-1:0] bw_str_done
);

  logic [11:0]          off;
  logic                 hit;
  logic [2:0]           sel;
  logic [IDW-1:0]       sid;
  logic                 unused_addr;

  logic [31:0]          str_rd [STR_NUM];
  logic [LEN_W-1:0]     len_v  [STR_NUM];
  logic [STR_NUM-1:0]   pend_nz;
  logic [STR_NUM-1:0]   gnt;

  logic                 vld_q;
  logic [IDW+LEN_W-1:0] dat_q;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       gid;
  logic                 found;
  logic                 load;

  assign unused_addr = ^up_addr[31:12];
  assign off = up_addr[11:0] - BASE_ADDR;
  assign hit = ({20'd0, off} < STR_NUM * 32) &&
               (off[1:0] == 2'b00);
  assign sel = off[4:2];
  assign sid = off[5 +: IDW];

  assign load          = !vld_q || bw_rate.ready;
  assign bw_rate.valid = vld_q;
  assign bw_rate.data  = dat_q;

  for (genvar k = 0; k < STR_NUM; k++) begin : g_str
    logic [ACC_W-1:0]  incr;
    logic [ACC_W-1:0]  acc;
    logic [SCAL_W-1:0] scal;
    logic [SCAL_W-1:0] scal_cnt;
    logic [SCAL_W-1:0] scal_eff;
    logic [LEN_W-1:0]  len;
    logic [31:0]       bcnt;
    logic [31:0]       sent;
    logic [PEND_W-1:0] pend;
    logic [ACC_W:0]    sum;
    logic [32:0]       fill;
    logic [31:0]       rd;
    logic              en;
    logic              burst;
    logic              carry_r;
    logic              ovf;
    logic              wr;
    logic              tick;
    logic              gate;
    logic              tick_ok;

    assign wr       = up_wr && hit && (sid == IDW'(k));
    assign sum      = {1'b0, acc} + {1'b0, incr};
    assign scal_eff = (scal == '0) ? SCAL_W'(1) : scal;
    assign tick     = carry_r &&
                      (scal_cnt >= scal_eff - SCAL_W'(1));
    // Outstanding plus launched credits cap a burst.
    assign fill     = {1'b0, sent} + 33'(pend);
    assign gate     = burst && (fill >= {1'b0, bcnt});
    assign tick_ok  = tick && !gate;

    assign bw_str_done[k] = burst && (sent >= bcnt);
    assign pend_nz[k]     = (pend != '0);
    assign len_v[k]       = len;
    assign str_rd[k]      = rd;

    always_comb begin
      rd = 32'hdeadbeef;
      case (sel)
        3'd0: rd = 32'(incr);
        3'd1: rd = 32'(scal);
        3'd2: rd = 32'(len);
        3'd3: rd = {30'd0, burst, en};
        3'd4: rd = bcnt;
        3'd5: rd = sent;
        3'd6: rd = {ovf, 31'(pend)};
        default: rd = 32'hdeadbeef;
      endcase
    end

    always_ff @(posedge up_clk or posedge rst) begin
      if (rst) begin
        incr     <= '0;
        scal     <= '0;
        len      <= '0;
        en       <= 1'b0;
        burst    <= 1'b0;
        bcnt     <= '0;
        acc      <= '0;
        carry_r  <= 1'b0;
        scal_cnt <= '0;
        pend     <= '0;
        ovf      <= 1'b0;
        sent     <= '0;
      end else begin
        if (wr) begin
          case (sel)
            3'd0: incr  <= up_data_wr[ACC_W-1:0];
            3'd1: scal  <= up_data_wr[SCAL_W-1:0];
            3'd2: len   <= up_data_wr[LEN_W-1:0];
            3'd3: begin
              en    <= up_data_wr[0];
              burst <= up_data_wr[1];
            end
            3'd4: bcnt  <= up_data_wr;
            default: ;
          endcase
        end
        if (tx_test_pulse) begin
          acc      <= '0;
          carry_r  <= 1'b0;
          scal_cnt <= '0;
          pend     <= '0;
          ovf      <= 1'b0;
          sent     <= '0;
        end else begin
          if (tx_test_level) begin
            if (en) acc <= sum[ACC_W-1:0];
            carry_r <= en && sum[ACC_W];
          end else begin
            carry_r <= 1'b0;
          end
          if (carry_r)
            scal_cnt <= tick ? '0 : scal_cnt + SCAL_W'(1);
          if (gnt[k]) sent <= sent + 32'd1;
          if (tick_ok && (&pend) && !gnt[k])
            ovf <= 1'b1;
          else
            pend <= pend + PEND_W'(tick_ok) -
                    PEND_W'(gnt[k]);
        end
      end
    end
  end

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    gid   = '0;
    gnt   = '0;
    for (int i = 0; i < STR_NUM; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= STR_NUM) j = j - STR_NUM;
      if (!found && pend_nz[j[IDW-1:0]]) begin
        found = 1'b1;
        gid   = j[IDW-1:0];
      end
    end
    if (found && load) gnt[gid] = 1'b1;
  end

  always_ff @(posedge up_clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      rr_ptr <= '0;
    end else if (tx_test_pulse) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      rr_ptr <= '0;
    end else if (load) begin
      vld_q <= found;
      if (found) begin
        dat_q  <= {gid, len_v[gid]};
        rr_ptr <= (int'(gid) == STR_NUM - 1) ?
                  '0 : gid + IDW'(1);
      end
    end
  end

  always_ff @(posedge up_clk or posedge rst) begin
    if (rst)
      up_data_rd <= '0;
    else if (up_rd)
      up_data_rd <= hit ? str_rd[sid] : 32'hdeadbeef;
  end

endmodule
